ccd_dmem_packer: RTL and testbench

Capture-side packer between the camera grayscale/downsample stage and dmem port B. It accepts a 12-bit grayscale pixel stream, reduces each pixel to an 8-bit value in a 16-bit lane, and packs 16 lanes per 256-bit word. It writes one frame of NUM_PIXELS pixels (default 28x28 = 784, i.e. 49 words) to dmem, then reports completion to the CPU through the enable/done handshake.

---
 rtl/ccd_pkg.sv | 23 ++
 rtl/ccd_lane_buf.sv | 39 +++
 rtl/ccd_dmem_packer.sv | 145 ++++++++++++++
 tb/tb_ccd_dmem_packer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared types and helpers for the capture-side dmem packer.
package ccd_pkg;

    localparam int LANES      = 16;
    localparam int LANE_W     = 16;
    localparam int WORD_W     = 256;
    localparam int DADDR_W    = 7;
    localparam int PIX_W      = 12;
    localparam int LANE_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } ccd_state_e;

    // Keep the top 8 bits of the grayscale sample, zero-extended into a lane.
    function automatic logic [LANE_W-1:0] pix_to_lane(input logic [PIX_W-1:0] pix);
        return {8'h00, pix[PIX_W-1 -: 8]};
    endfunction

endpackage

// File: rtl/ccd_lane_buf.sv
// 16 x 16-bit lane register; one lane written per cycle, clear zeroes every other lane.
module ccd_lane_buf
    import ccd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANE_IDX_W-1:0] lane_idx,
    input  logic                  wr_en,
    input  logic [LANE_W-1:0]     wr_lane,
    input  logic                  clr,
    output logic [WORD_W-1:0]     word
);

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;

    // A write and a clear in the same cycle leave only the written lane populated.
    always_comb begin
        word_d = word_q;
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && (lane_idx == LANE_IDX_W'(i))) begin
                word_d[i*LANE_W +: LANE_W] = wr_lane;
            end else if (clr) begin
                word_d[i*LANE_W +: LANE_W] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/ccd_dmem_packer.sv
// Packs one frame of 12-bit grayscale pixels, 16 per 256-bit word, into dmem port B,
// then holds done until the CPU drops enable.
module ccd_dmem_packer
    import ccd_pkg::*;
#(
    parameter int                  NUM_PIXELS = 784,
    parameter logic [DADDR_W-1:0]  BASE_ADDR  = 7'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic                done,
    output logic                busy,
    input  logic                pix_valid,
    input  logic                pix_sof,
    input  logic [PIX_W-1:0]    pix_data,
    output logic                dmem_wren,
    output logic [DADDR_W-1:0]  dmem_wraddr,
    output logic [WORD_W-1:0]   dmem_wrdata
);

    localparam int              CNT_W    = 12;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);

    ccd_state_e         state_q,    state_d;
    logic [CNT_W-1:0]   pix_cnt_q,  pix_cnt_d;
    logic [DADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic               wren_q,     wren_d;
    logic [DADDR_W-1:0] wraddr_q,   wraddr_d;
    logic [WORD_W-1:0]  wrdata_q,   wrdata_d;
    logic               done_q,     done_d;
    logic               busy_q,     busy_d;

    logic [WORD_W-1:0]     lb_word;
    logic                  lb_wr;
    logic                  lb_clr;
    logic [LANE_IDX_W-1:0] lane_idx;
    logic [LANE_W-1:0]     new_lane;
    logic [WORD_W-1:0]     merged;
    logic [CNT_W-1:0]      eff_cnt;
    logic [DADDR_W-1:0]    eff_addr;
    logic                  fresh;
    logic                  accept;
    logic                  is_last;
    logic                  do_write;

    ccd_lane_buf u_lane_buf (
        .clk      (clk),
        .rst      (rst),
        .lane_idx (lane_idx),
        .wr_en    (lb_wr),
        .wr_lane  (new_lane),
        .clr      (lb_clr),
        .word     (lb_word)
    );

    // A SOF pixel (first in ARMED, or a restart in CAPTURE) is always pixel 0 of an empty word.
    always_comb begin
        fresh    = (state_q == ST_ARMED) || pix_sof;
        accept   = enable && pix_valid &&
                   (((state_q == ST_ARMED) && pix_sof) || (state_q == ST_CAPTURE));
        eff_cnt  = fresh ? '0 : pix_cnt_q;
        eff_addr = fresh ? BASE_ADDR : addr_cnt_q;
        lane_idx = eff_cnt[LANE_IDX_W-1:0];
        new_lane = pix_to_lane(pix_data);
        merged   = fresh ? '0 : lb_word;
        merged[lane_idx*LANE_W +: LANE_W] = new_lane;
        is_last  = (eff_cnt == LAST_PIX);
        do_write = accept && (is_last || (lane_idx == '1));
    end

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        addr_cnt_d = addr_cnt_q;
        wren_d     = 1'b0;
        wraddr_d   = wraddr_q;
        wrdata_d   = wrdata_q;
        lb_wr      = 1'b0;
        lb_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pix_cnt_d  = '0;
                addr_cnt_d = BASE_ADDR;
                lb_clr     = 1'b1;
                if (enable) state_d = ST_ARMED;
            end
            ST_ARMED, ST_CAPTURE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    pix_cnt_d = eff_cnt + CNT_W'(1);
                    state_d   = is_last ? ST_DONE : ST_CAPTURE;
                    if (do_write) begin
                        wren_d     = 1'b1;
                        wraddr_d   = eff_addr;
                        wrdata_d   = merged;
                        addr_cnt_d = eff_addr + DADDR_W'(1);
                        lb_clr     = 1'b1;
                    end else begin
                        addr_cnt_d = eff_addr;
                        lb_wr      = 1'b1;
                        lb_clr     = fresh;
                    end
                end
            end
            default: begin
                if (!enable) state_d = ST_IDLE;
            end
        endcase
        // busy covers the final write cycle and falls exactly as done rises.
        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE) ||
                 ((state_d == ST_DONE) && (state_q != ST_DONE));
        done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= '0;
            addr_cnt_q <= BASE_ADDR;
            wren_q     <= 1'b0;
            wraddr_q   <= BASE_ADDR;
            wrdata_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            wren_q     <= wren_d;
            wraddr_q   <= wraddr_d;
            wrdata_q   <= wrdata_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign done        = done_q;
    assign busy        = busy_q;
    assign dmem_wren   = wren_q;
    assign dmem_wraddr = wraddr_q;
    assign dmem_wrdata = wrdata_q;

endmodule

// File: tb/tb_ccd_dmem_packer.sv
// Bench for ccd_dmem_packer: four instances (784/0, 20/0, 784/120, 3/5) on a shared pixel bus.
module tb_ccd_dmem_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   en_w;
    logic         pix_valid;
    logic         pix_sof;
    logic [11:0]  pix_data;
    logic [3:0]   done_w;
    logic [3:0]   busy_w;
    logic [3:0]   wren_w;
    logic [6:0]   addr_w [4];
    logic [255:0] data_w [4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int         NP = (g == 1) ? 20 : (g == 3) ? 3 : 784;
        localparam logic [6:0] BA = (g == 2) ? 7'd120 : (g == 3) ? 7'd5 : 7'd0;
        ccd_dmem_packer #(.NUM_PIXELS(NP), .BASE_ADDR(BA)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .enable      (en_w[g]),
            .done        (done_w[g]),
            .busy        (busy_w[g]),
            .pix_valid   (pix_valid),
            .pix_sof     (pix_sof),
            .pix_data    (pix_data),
            .dmem_wren   (wren_w[g]),
            .dmem_wraddr (addr_w[g]),
            .dmem_wrdata (data_w[g])
        );
    end

    // Write monitor: memory image, write count, spacing and done timing per instance.
    logic         mon_clr;
    logic [255:0] mem [4][128];
    int           hit [4][128];
    int           wr_cnt [4];
    int           last_wr [4];
    int           done_cyc [4];
    int           min_gap [4];
    int           max_gap [4];
    logic         busy_at_done [4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mon_clr) begin
                wr_cnt[i] = 0; last_wr[i] = -1; done_cyc[i] = -1;
                min_gap[i] = 1000000; max_gap[i] = 0; busy_at_done[i] = 1'b1;
                for (int a = 0; a < 128; a++) begin
                    mem[i][a] = '0;
                    hit[i][a] = 0;
                end
            end else begin
                if (wren_w[i]) begin
                    mem[i][addr_w[i]] = data_w[i];
                    hit[i][addr_w[i]] = hit[i][addr_w[i]] + 1;
                    if (last_wr[i] >= 0) begin
                        if (cyc - last_wr[i] < min_gap[i]) min_gap[i] = cyc - last_wr[i];
                        if (cyc - last_wr[i] > max_gap[i]) max_gap[i] = cyc - last_wr[i];
                    end
                    last_wr[i] = cyc;
                    wr_cnt[i]  = wr_cnt[i] + 1;
                end
                if (done_w[i] && done_cyc[i] < 0) begin
                    done_cyc[i]     = cyc;
                    busy_at_done[i] = busy_w[i];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    // Pixel k of a frame carries (k+off)[7:0] in its top byte and junk in the low nibble.
    task automatic send_pixels(input int start, input int n, input int gap, input int off,
                               input bit sof_first);
        for (int k = start; k < start + n; k++) begin
            pix_valid = 1'b1;
            pix_sof   = sof_first && (k == start);
            pix_data  = {8'(k + off), 4'(k)};
            tick();
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            repeat (gap) tick();
        end
    endtask

    function automatic logic [255:0] exp_word(input int w, input int np, input int off);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            if (16 * w + j < np) r[j*16 +: 16] = {8'h00, 8'(16 * w + j + off)};
        end
        return r;
    endfunction

    task automatic img_check(input string name, input int inst, input int base,
                             input int np, input int off);
        int bad;
        bad = 0;
        for (int w = 0; w < (np + 15) / 16; w++) begin
            if (mem[inst][(base + w) % 128] !== exp_word(w, np, off)) bad++;
        end
        chk(name, bad, 0);
    endtask

    typedef struct {
        logic        en;
        logic        v;
        logic        sof;
        logic [11:0] d;
        logic        busy;
        logic        done;
        logic        wren;
        logic [6:0]  addr;
        logic        chk_dat;
        logic [47:0] dat;
    } vec_t;

    vec_t vt [15];

    initial begin
        // Cycle table for the 3-pixel instance at BASE_ADDR 5; outputs sampled after each edge.
        vt[0]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 12'h120, 1'b1, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 12'h340, 1'b1, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 12'hAB3, 1'b1, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 12'hCD7, 1'b1, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 12'hEF5, 1'b1, 1'b0, 1'b1, 7'd5, 1'b1, 48'h00EF_00CD_00AB};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 12'h111, 1'b0, 1'b1, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[12] = '{1'b1, 1'b1, 1'b1, 12'h015, 1'b1, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[13] = '{1'b0, 1'b1, 1'b0, 12'h027, 1'b0, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};
        vt[14] = '{1'b0, 1'b1, 1'b0, 12'h039, 1'b0, 1'b0, 1'b0, 7'd5, 1'b0, 48'h0};

        rst = 1'b1; en_w = '0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        mon_clr = 1'b1;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_busy%0d", i), busy_w[i], 1'b0);
            chk($sformatf("reset_done%0d", i), done_w[i], 1'b0);
            chk($sformatf("reset_wren%0d", i), wren_w[i], 1'b0);
            chk($sformatf("reset_data%0d", i), data_w[i], '0);
            chk($sformatf("reset_addr%0d", i), addr_w[i], (i == 2) ? 7'd120 : (i == 3) ? 7'd5 : 7'd0);
        end
        rst = 1'b0;
        mon_clr = 1'b0;

        for (int r = 0; r < 15; r++) begin
            en_w[3] = vt[r].en; pix_valid = vt[r].v; pix_sof = vt[r].sof; pix_data = vt[r].d;
            tick();
            chk($sformatf("vec%0d_busy", r), busy_w[3], vt[r].busy);
            chk($sformatf("vec%0d_done", r), done_w[3], vt[r].done);
            chk($sformatf("vec%0d_wren", r), wren_w[3], vt[r].wren);
            chk($sformatf("vec%0d_addr", r), addr_w[3], vt[r].addr);
            if (vt[r].chk_dat) chk($sformatf("vec%0d_data", r), data_w[3], {208'h0, vt[r].dat});
        end
        pix_valid = 1'b0; pix_sof = 1'b0;

        // Full-rate frame into the 784/0, 20/0 and 784/120 instances at once.
        clear_mon();
        en_w = 4'b0111;
        tick();
        send_pixels(0, 784, 0, 0, 1'b1);
        repeat (4) tick();
        chk("full_wr_cnt", wr_cnt[0], 49);
        img_check("full_image", 0, 0, 784, 0);
        chk("full_word0_lane5", mem[0][0][95:80], 16'h0005);
        chk("full_hit48", hit[0][48], 1);
        chk("full_hit49", hit[0][49], 0);
        chk("full_done_delay", done_cyc[0] - last_wr[0], 1);
        chk("full_busy_at_done", busy_at_done[0], 1'b0);
        chk("full_min_gap", min_gap[0], 16);
        chk("full_max_gap", max_gap[0], 16);
        chk("full_done_level", done_w[0], 1'b1);
        chk("part_wr_cnt", wr_cnt[1], 2);
        chk("part_word1", mem[1][1], exp_word(1, 20, 0));
        chk("part_word0", mem[1][0], exp_word(0, 20, 0));
        chk("wrap_wr_cnt", wr_cnt[2], 49);
        chk("wrap_hit0", hit[2][0], 1);
        chk("wrap_word8", mem[2][0], exp_word(8, 784, 0));
        img_check("wrap_image", 2, 120, 784, 0);
        en_w = '0;
        tick(); tick();
        chk("full_done_clear", done_w[0], 1'b0);

        // Valid one cycle in three.
        clear_mon();
        en_w[0] = 1'b1;
        tick();
        send_pixels(0, 784, 2, 0, 1'b1);
        repeat (4) tick();
        chk("gappy_wr_cnt", wr_cnt[0], 49);
        img_check("gappy_image", 0, 0, 784, 0);
        chk("gappy_min_gap", min_gap[0], 48);
        chk("gappy_max_gap", max_gap[0], 48);
        chk("gappy_done_delay", done_cyc[0] - last_wr[0], 1);
        en_w[0] = 1'b0;
        tick(); tick();

        // Pixels before SOF are ignored; a second SOF at pixel 100 restarts the frame.
        clear_mon();
        en_w[0] = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 12'hFFF;
            tick();
        end
        pix_valid = 1'b0;
        send_pixels(0, 100, 0, 0, 1'b1);
        chk("presof_wr_cnt", wr_cnt[0], 6);
        chk("presof_word0", mem[0][0], exp_word(0, 784, 0));
        send_pixels(0, 784, 0, 77, 1'b1);
        repeat (4) tick();
        chk("resof_wr_cnt", wr_cnt[0], 55);
        chk("resof_hit0", hit[0][0], 2);
        img_check("resof_image", 0, 0, 784, 77);
        chk("resof_done", done_w[0], 1'b1);
        en_w[0] = 1'b0;
        tick(); tick();

        // enable dropped at pixel 300, then a fresh capture.
        clear_mon();
        en_w[0] = 1'b1;
        tick();
        send_pixels(0, 300, 0, 0, 1'b1);
        en_w[0] = 1'b0;
        send_pixels(300, 20, 0, 0, 1'b0);
        tick(); tick();
        chk("abort_wr_cnt", wr_cnt[0], 18);
        chk("abort_no_done", done_cyc[0], -1);
        chk("abort_busy", busy_w[0], 1'b0);
        en_w[0] = 1'b1;
        tick();
        send_pixels(0, 784, 0, 33, 1'b1);
        repeat (4) tick();
        chk("reen_wr_cnt", wr_cnt[0], 67);
        img_check("reen_image", 0, 0, 784, 33);
        chk("reen_done", done_w[0], 1'b1);
        en_w[0] = 1'b0;
        tick(); tick();

        // Reset landing on a write strobe of the BASE_ADDR=120 instance.
        en_w[2] = 1'b1;
        tick();
        send_pixels(0, 32, 0, 0, 1'b1);
        chk("prerst_wren", wren_w[2], 1'b1);
        chk("prerst_addr", addr_w[2], 7'd121);
        rst = 1'b1;
        en_w = '0;
        tick();
        chk("rst_wren", wren_w[2], 1'b0);
        chk("rst_busy", busy_w[2], 1'b0);
        chk("rst_done", done_w[2], 1'b0);
        chk("rst_addr", addr_w[2], 7'd120);
        chk("rst_data", data_w[2], '0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
